// File: rtl/led_shift_driver_pkg.sv
// Shared state encoding and counter-width helpers for the daisy-chained
// shift-register LED driver.
package led_drv_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } led_state_e;

   // Phase counter must hold CLK_DIV-1; one spare bit keeps CLK_DIV=1 legal.
   function automatic int phase_cnt_w(input int clk_div);
      return $clog2(clk_div) + 32'sd1;
   endfunction

   // Bit counter must reach DATA_W itself after the last bit.
   function automatic int bit_cnt_w(input int data_w);
      return $clog2(data_w) + 32'sd1;
   endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Loadable down-counter of CLK_DIV cycles; flags the last cycle of a phase
// and the cycle before it.
module led_phase_timer
   import led_drv_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic terminal,
   output logic penult
);

   localparam int              PH_W     = phase_cnt_w(CLK_DIV);
   localparam logic [PH_W-1:0] LOAD_VAL = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_ZERO  = PH_W'(0);
   localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);

   logic [PH_W-1:0] count_r;
   logic            running_r;

   assign terminal = running_r && (count_r == PH_ZERO);
   assign penult   = running_r && (count_r == PH_ONE);

   // Count down from the load value; stop after the terminal cycle unless reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r   <= PH_ZERO;
         running_r <= 1'b0;
      end else if (load) begin
         count_r   <= LOAD_VAL;
         running_r <= 1'b1;
      end else if (terminal) begin
         running_r <= 1'b0;
      end else if (running_r) begin
         count_r   <= count_r - PH_ONE;
      end
   end

endmodule

// File: rtl/led_shift_driver.sv
// Serial driver for 74HC595-style LED chains: accepts a parallel frame,
// shifts it out with a divided shift clock, then pulses the storage latch.
module led_shift_driver
   import led_drv_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int CLK_DIV   = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic              i_CLK,
   input  logic              i_RESET_n,
   input  logic [DATA_W-1:0] i_Data,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic              i_Blank,
   output logic              o_LEDData,
   output logic              o_LEDClk,
   output logic              o_LEDLatch,
   output logic              o_LEDOE_n,
   output logic              o_Done
);

   localparam int              BC_W     = bit_cnt_w(DATA_W);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0] BIT_ZERO = BC_W'(0);
   localparam logic [BC_W-1:0] BIT_ONE  = BC_W'(1);
   localparam bit              MSB_SEL  = (MSB_FIRST != 32'sd0);
   // With single-cycle phases the only LATCH cycle is also the final one.
   localparam logic            DONE_ON_ENTRY = (CLK_DIV == 32'sd1) ? 1'b1 : 1'b0;

   led_state_e        state_r;
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] shifted_s;
   logic [BC_W-1:0]   bit_cnt_r;
   logic              ready_r;
   logic              data_r;
   logic              led_clk_r;
   logic              latch_r;
   logic              done_r;
   logic              oe_n_r;
   logic              shown_r;
   logic              load_s;
   logic              phase_end_s;
   logic              phase_penult_s;
   logic              first_bit_s;
   logic              next_bit_s;

   led_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk      (i_CLK),
      .rst_n    (i_RESET_n),
      .load     (load_s),
      .terminal (phase_end_s),
      .penult   (phase_penult_s)
   );

   // Shift direction: next register value and the bit presented in each LO phase.
   always_comb begin
      shifted_s   = shift_r;
      next_bit_s  = 1'b0;
      first_bit_s = 1'b0;
      if (MSB_SEL) begin
         shifted_s   = shift_r << 32'd1;
         next_bit_s  = shifted_s[DATA_W-1];
         first_bit_s = i_Data[DATA_W-1];
      end else begin
         shifted_s   = shift_r >> 32'd1;
         next_bit_s  = shifted_s[0];
         first_bit_s = i_Data[0];
      end
   end

   // Restart the phase timer on every phase entry.
   always_comb begin
      load_s = 1'b0;
      case (state_r)
         IDLE:     load_s = i_Valid;
         SHIFT_LO: load_s = phase_end_s;
         SHIFT_HI: load_s = phase_end_s;
         LATCH:    load_s = 1'b0;
         default:  load_s = 1'b0;
      endcase
   end

   // Frame FSM with registered pin outputs.
   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         state_r   <= IDLE;
         shift_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= BIT_ZERO;
         ready_r   <= 1'b1;
         data_r    <= 1'b0;
         led_clk_r <= 1'b0;
         latch_r   <= 1'b0;
         done_r    <= 1'b0;
         shown_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_Valid) begin
                  shift_r   <= i_Data;
                  data_r    <= first_bit_s;
                  bit_cnt_r <= BIT_ZERO;
                  ready_r   <= 1'b0;
                  state_r   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_end_s) begin
                  led_clk_r <= 1'b1;
                  state_r   <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (phase_end_s) begin
                  led_clk_r <= 1'b0;
                  bit_cnt_r <= bit_cnt_r + BIT_ONE;
                  shift_r   <= shifted_s;
                  if (bit_cnt_r == LAST_BIT) begin
                     latch_r <= 1'b1;
                     done_r  <= DONE_ON_ENTRY;
                     state_r <= LATCH;
                  end else begin
                     data_r  <= next_bit_s;
                     state_r <= SHIFT_LO;
                  end
               end
            end
            LATCH: begin
               if (phase_end_s) begin
                  latch_r <= 1'b0;
                  done_r  <= 1'b0;
                  ready_r <= 1'b1;
                  shown_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  done_r  <= phase_penult_s;
               end
            end
            default: begin
               led_clk_r <= 1'b0;
               latch_r   <= 1'b0;
               done_r    <= 1'b0;
               ready_r   <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // Output enable stays off until a full frame has been latched into the chain.
   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         oe_n_r <= 1'b1;
      end else if (shown_r) begin
         oe_n_r <= i_Blank;
      end else begin
         oe_n_r <= 1'b1;
      end
   end

   assign o_Ready    = ready_r;
   assign o_LEDData  = data_r;
   assign o_LEDClk   = led_clk_r;
   assign o_LEDLatch = latch_r;
   assign o_LEDOE_n  = oe_n_r;
   assign o_Done     = done_r;

endmodule

// File: tb/tb_led_shift_driver.sv
// Scoreboard bench: two driver instances (divide-by-1 MSB-first, divide-by-3 LSB-first).
`timescale 1ns/1ps
module tb_led_shift_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] a_data, b_data;
   logic        a_valid, b_valid, a_blank, b_blank;
   logic        a_ready, a_dat, a_clk, a_latch, a_oe_n, a_done;
   logic        b_ready, b_dat, b_clk, b_latch, b_oe_n, b_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bit   obs_a[$];
   bit   obs_b[$];
   bit   exp_a[$];
   bit   exp_b[$];
   logic a_clk_prev = 1'b0;
   logic b_clk_prev = 1'b0;

   led_shift_driver #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1)) u_dut_a (
      .i_CLK(clk), .i_RESET_n(rst_n), .i_Data(a_data), .i_Valid(a_valid),
      .o_Ready(a_ready), .i_Blank(a_blank), .o_LEDData(a_dat), .o_LEDClk(a_clk),
      .o_LEDLatch(a_latch), .o_LEDOE_n(a_oe_n), .o_Done(a_done));

   led_shift_driver #(.DATA_W(16), .CLK_DIV(3), .MSB_FIRST(0)) u_dut_b (
      .i_CLK(clk), .i_RESET_n(rst_n), .i_Data(b_data), .i_Valid(b_valid),
      .o_Ready(b_ready), .i_Blank(b_blank), .o_LEDData(b_dat), .o_LEDClk(b_clk),
      .o_LEDLatch(b_latch), .o_LEDOE_n(b_oe_n), .o_Done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Chain model: capture the data bit at every shift-clock rising edge.
   always @(negedge clk) begin
      if (a_clk && !a_clk_prev) obs_a.push_back(a_dat);
      if (b_clk && !b_clk_prev) obs_b.push_back(b_dat);
      a_clk_prev <= a_clk;
      b_clk_prev <= b_clk;
   end

   task automatic test_reset;
      rst_n = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n,
              b_ready, b_clk, b_latch, b_dat, b_done, b_oe_n} !== 12'b100001_100001) begin
            errors++;
            $display("FAIL reset_hold got a=%b%b%b%b%b%b b=%b%b%b%b%b%b want 100001",
                     a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n,
                     b_ready, b_clk, b_latch, b_dat, b_done, b_oe_n);
         end
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n,
              b_ready, b_clk, b_latch, b_dat, b_done, b_oe_n} !== 12'b100001_100001) begin
            errors++;
            $display("FAIL reset_idle got a=%b%b%b%b%b%b b=%b%b%b%b%b%b want 100001",
                     a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n,
                     b_ready, b_clk, b_latch, b_dat, b_done, b_oe_n);
         end
      end
   endtask

   // One complete frame on instance A with optional blanking window.
   task automatic frame_a(input logic [15:0] d, input int blank_at, input bit shown_before);
      int   c0, base, t_done, t_ready, n_latch, n_done, oe_bad;
      logic bl_prev, exp_oe, exp_bit;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL frame_ready_before got %b want 1", a_ready);
      end
      base = obs_a.size();
      for (int i = 15; i >= 0; i--) exp_a.push_back(d[i]);
      c0 = cyc;
      a_data = d;
      a_valid = 1'b1;
      t_done = -1; t_ready = -1; n_latch = 0; n_done = 0; oe_bad = 0; bl_prev = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         a_valid = 1'b0;
         if (a_latch === 1'b1) n_latch++;
         if (a_done === 1'b1) begin
            n_done++;
            t_done = cyc - c0;
         end
         if (a_ready === 1'b1 && t_ready < 0) t_ready = cyc - c0;
         exp_oe = (!shown_before && k < 35) ? 1'b1 : bl_prev;
         if (a_oe_n !== exp_oe) oe_bad++;
         a_blank = (blank_at > 0 && k >= blank_at && k < blank_at + 5);
         bl_prev = a_blank;
         a_data = k[0] ? ~d : 16'h1234;
      end
      checks++;
      if (t_done != 33 || n_done != 1) begin
         errors++;
         $display("FAIL frame_done got cycle %0d count %0d want cycle 33 count 1", t_done, n_done);
      end
      checks++;
      if (n_latch != 1) begin
         errors++;
         $display("FAIL frame_latch got %0d cycles want 1", n_latch);
      end
      checks++;
      if (t_ready != 34) begin
         errors++;
         $display("FAIL frame_ready_return got cycle %0d want 34", t_ready);
      end
      checks++;
      if (oe_bad != 0) begin
         errors++;
         $display("FAIL frame_oe got %0d wrong cycles want 0", oe_bad);
      end
      checks++;
      if (obs_a.size() - base != 16) begin
         errors++;
         $display("FAIL frame_edges got %0d want 16", obs_a.size() - base);
      end
      for (int i = 0; i < 16; i++) begin
         exp_bit = exp_a.pop_front();
         checks++;
         if (base + i >= obs_a.size() || obs_a[base + i] !== exp_bit) begin
            errors++;
            $display("FAIL frame_bit%0d got %b want %b", i,
                     (base + i < obs_a.size()) ? obs_a[base + i] : 1'bx, exp_bit);
         end
      end
   endtask

   task automatic test_default_frame;
      frame_a(16'h4886, 0, 1'b0);
   endtask

   task automatic test_divider_lsb;
      int          c0, base, clk_bad, n_latch, n_done, t_done, t_ready;
      logic        exp_clk, exp_bit;
      logic [15:0] d;
      d = 16'h0001;
      @(negedge clk);
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("FAIL div_ready_before got %b want 1", b_ready);
      end
      base = obs_b.size();
      for (int i = 0; i < 16; i++) exp_b.push_back(d[i]);
      c0 = cyc;
      b_data = d;
      b_valid = 1'b1;
      clk_bad = 0; n_latch = 0; n_done = 0; t_done = -1; t_ready = -1;
      for (int k = 1; k <= 102; k++) begin
         @(negedge clk);
         b_valid = 1'b0;
         b_data = k[0] ? 16'hFFFF : 16'h8000;
         exp_clk = (k <= 96) && (((k - 1) / 3) % 2 == 1);
         if (b_clk !== exp_clk) clk_bad++;
         if (b_latch === 1'b1) n_latch++;
         if (b_done === 1'b1) begin
            n_done++;
            t_done = cyc - c0;
         end
         if (b_ready === 1'b1 && t_ready < 0) t_ready = cyc - c0;
      end
      checks++;
      if (clk_bad != 0) begin
         errors++;
         $display("FAIL div_clk_shape got %0d wrong cycles want 0", clk_bad);
      end
      checks++;
      if (n_latch != 3) begin
         errors++;
         $display("FAIL div_latch got %0d cycles want 3", n_latch);
      end
      checks++;
      if (t_done != 99 || n_done != 1) begin
         errors++;
         $display("FAIL div_done got cycle %0d count %0d want cycle 99 count 1", t_done, n_done);
      end
      checks++;
      if (t_ready != 100) begin
         errors++;
         $display("FAIL div_ready_return got cycle %0d want 100", t_ready);
      end
      checks++;
      if (obs_b.size() - base != 16) begin
         errors++;
         $display("FAIL div_edges got %0d want 16", obs_b.size() - base);
      end
      for (int i = 0; i < 16; i++) begin
         exp_bit = exp_b.pop_front();
         checks++;
         if (base + i >= obs_b.size() || obs_b[base + i] !== exp_bit) begin
            errors++;
            $display("FAIL div_bit%0d got %b want %b", i,
                     (base + i < obs_b.size()) ? obs_b[base + i] : 1'bx, exp_bit);
         end
      end
   endtask

   task automatic test_back_to_back;
      int          base, n_done, t_first, t_last;
      logic        r34, r35, r68, exp_bit;
      logic [15:0] d1, d2;
      d1 = 16'hAAAA;
      d2 = 16'h5555;
      @(negedge clk);
      base = obs_a.size();
      for (int i = 15; i >= 0; i--) exp_a.push_back(d1[i]);
      a_data = d1;
      a_valid = 1'b1;
      n_done = 0; t_first = -1; t_last = -1; r34 = 1'bx; r35 = 1'bx; r68 = 1'bx;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (k == 34) r34 = a_ready;
         if (k == 35) r35 = a_ready;
         if (k == 68) r68 = a_ready;
         if (a_done === 1'b1) begin
            n_done++;
            if (t_first < 0) t_first = k;
            t_last = k;
         end
         a_valid = (k < 35);
         if (k < 30)       a_data = k[0] ? 16'h0F0F : d2;
         else if (k < 35)  a_data = d2;
         else              a_data = k[0] ? 16'hFFFF : 16'h0000;
         if (k == 34) begin
            for (int i = 15; i >= 0; i--) exp_a.push_back(d2[i]);
         end
      end
      checks++;
      if (r34 !== 1'b1 || r35 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept got ready %b,%b want 1,0", r34, r35);
      end
      checks++;
      if (n_done != 2 || t_first != 33 || t_last != 67) begin
         errors++;
         $display("FAIL b2b_done got count %0d at %0d,%0d want 2 at 33,67", n_done, t_first, t_last);
      end
      checks++;
      if (r68 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_end got %b want 1", r68);
      end
      checks++;
      if (obs_a.size() - base != 32) begin
         errors++;
         $display("FAIL b2b_edges got %0d want 32", obs_a.size() - base);
      end
      for (int i = 0; i < 32; i++) begin
         exp_bit = exp_a.pop_front();
         checks++;
         if (base + i >= obs_a.size() || obs_a[base + i] !== exp_bit) begin
            errors++;
            $display("FAIL b2b_bit%0d got %b want %b", i,
                     (base + i < obs_a.size()) ? obs_a[base + i] : 1'bx, exp_bit);
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      int base, n_pulse, oe_bad;
      @(negedge clk);
      base = obs_a.size();
      a_data = 16'hFFFF;
      a_valid = 1'b1;
      n_pulse = 0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         a_valid = 1'b0;
         if (a_latch === 1'b1 || a_done === 1'b1) n_pulse++;
      end
      checks++;
      if ({a_ready, a_clk, a_dat, a_oe_n} !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_before got rdy/clk/dat/oe %b%b%b%b want 0010",
                  a_ready, a_clk, a_dat, a_oe_n);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n} !== 6'b100001) begin
         errors++;
         $display("FAIL midrst_async got %b%b%b%b%b%b want 100001",
                  a_ready, a_clk, a_latch, a_dat, a_done, a_oe_n);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      oe_bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_latch === 1'b1 || a_done === 1'b1) n_pulse++;
         if (a_oe_n !== 1'b1) oe_bad++;
      end
      checks++;
      if (n_pulse != 0) begin
         errors++;
         $display("FAIL midrst_no_pulse got %0d pulse cycles want 0", n_pulse);
      end
      checks++;
      if (oe_bad != 0) begin
         errors++;
         $display("FAIL midrst_oe got %0d enabled cycles want 0", oe_bad);
      end
      checks++;
      if (obs_a.size() - base != 8) begin
         errors++;
         $display("FAIL midrst_edges got %0d want 8", obs_a.size() - base);
      end
      frame_a(16'hC3A5, 0, 1'b0);
   endtask

   task automatic test_blanking;
      frame_a(16'h0F1E, 5, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
      a_blank = 1'b0; b_blank = 1'b0;
      a_data = 16'h0000; b_data = 16'h0000;
      test_reset();
      test_default_frame();
      test_divider_lsb();
      test_back_to_back();
      test_reset_mid_frame();
      test_blanking();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
